// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg: shared UART constants and receive-FIFO capture-state encodings
package uart_rx_fifo_pkg;
    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD = 115_200;
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int UART_RXFIFO_DEPTH_LOG2 = 4;
    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_ACK  = 2'd1,
        C_WAIT = 2'd2
    } cap_state_t;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: bus-side pop/status/irq signals of the UART receive FIFO
interface uart_rx_fifo_if import uart_rx_fifo_pkg::*; #(
    parameter int DEPTH_LOG2 = UART_RXFIFO_DEPTH_LOG2
);
    logic rd_en, clr_overrun, empty, full, overrun, irq;
    logic [7:0] rd_data;
    logic [DEPTH_LOG2:0] count;
    modport master(output rd_en, clr_overrun, input rd_data, empty, full, count, overrun, irq);
    modport slave(input rd_en, clr_overrun, output rd_data, empty, full, count, overrun, irq);
endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// uart_rx_fifo_sync_fifo: first-word-fall-through register FIFO with a separate occupancy counter
module uart_rx_fifo_sync_fifo #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          push_ok,
    output logic [AW:0]   count,
    output logic [AW:0]   count_nxt,
    output logic          empty,
    output logic          full
);
    localparam logic [AW:0] DEPTH = (AW+1)'(2 ** AW);
    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic pop_ok;
    // a pop in the same cycle frees the slot a push at full needs
    always_comb begin
        pop_ok = pop & ~empty;
        push_ok = push & (~full | pop_ok);
        count_nxt = count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
    assign empty = count == '0;
    assign full = count == DEPTH;
    assign rdata = mem[rd_ptr];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
        end
    end
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures bytes from the UART receiver, acknowledges them and buffers them for the bus
module uart_rx_fifo import uart_rx_fifo_pkg::*; #(
    parameter int DEPTH_LOG2 = UART_RXFIFO_DEPTH_LOG2,
    parameter int IRQ_LEVEL = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_rs,
    output logic          over_read,
    uart_rx_fifo_if.slave bus
);
    localparam logic [DEPTH_LOG2:0] IRQ_LVL = (DEPTH_LOG2+1)'(IRQ_LEVEL);
    cap_state_t state, state_nxt;
    logic rs_s1, rs_s2, cap, push_ok, overrun_nxt;
    logic [DEPTH_LOG2:0] count_nxt;
    uart_rx_fifo_sync_fifo #(.AW(DEPTH_LOG2), .DW(8)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(cap),
        .pop(bus.rd_en),
        .wdata(rx_data),
        .rdata(bus.rd_data),
        .push_ok(push_ok),
        .count(bus.count),
        .count_nxt(count_nxt),
        .empty(bus.empty),
        .full(bus.full)
    );
    // rx_rs comes from the receiver's derived clock, hence the two-flop synchronizer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rs_s1 <= 1'b0;
            rs_s2 <= 1'b0;
            state <= C_IDLE;
            over_read <= 1'b0;
            bus.overrun <= 1'b0;
            bus.irq <= 1'b0;
        end else begin
            rs_s1 <= rx_rs;
            rs_s2 <= rs_s1;
            state <= state_nxt;
            over_read <= cap;
            bus.overrun <= overrun_nxt;
            bus.irq <= (count_nxt >= IRQ_LVL) | overrun_nxt;
        end
    end
    // C_WAIT holds off until rs drops so one assertion yields exactly one capture
    always_comb begin
        state_nxt = state;
        cap = 1'b0;
        case (state)
            C_IDLE: begin
                cap = rs_s2;
                state_nxt = rs_s2 ? C_ACK : C_IDLE;
            end
            C_ACK: state_nxt = C_WAIT;
            C_WAIT: state_nxt = rs_s2 ? C_WAIT : C_IDLE;
            default: state_nxt = C_IDLE;
        endcase
        overrun_nxt = (cap & ~push_ok) | (bus.overrun & ~bus.clr_overrun);
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed plus randomized checks of uart_rx_fifo against a queue-based model
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int IRQ_LEVEL = 1;
    logic clk = 1'b0;
    logic rst;
    logic [7:0] rx_data;
    logic rx_rs, over_read;
    bit hold_rs;
    int cyc, rs_t, gap, n_or, n_chk, n_err, n0;
    logic [7:0] q[$];
    logic ovr;

    uart_rx_fifo_if #(.DEPTH_LOG2(4)) bus();

    uart_rx_fifo #(.DEPTH_LOG2(4), .IRQ_LEVEL(IRQ_LEVEL)) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_rs(rx_rs),
        .over_read(over_read),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // one clock: advance the reference model by what was driven, then compare
    task automatic tick();
        int sz;
        logic pop_l, acc, drop;
        sz = q.size();
        @(posedge clk);
        #1;
        cyc++;
        pop_l = bus.rd_en && sz > 0;
        acc = over_read && (sz < DEPTH || pop_l);
        drop = over_read && !acc;
        if (over_read) begin
            n_or++;
            if (rs_t >= 0) begin
                chk("or_latency", cyc - rs_t, 3);
                rs_t = -1;
            end
        end
        if (pop_l) void'(q.pop_front());
        if (acc) q.push_back(rx_data);
        ovr = drop | (ovr & ~bus.clr_overrun);
        chk("count", bus.count, q.size());
        chk("empty", bus.empty, q.size() == 0);
        chk("full", bus.full, q.size() == DEPTH);
        chk("overrun", bus.overrun, ovr);
        chk("irq", bus.irq, (q.size() >= IRQ_LEVEL) || ovr);
        if (q.size() > 0) chk("rd_data", bus.rd_data, q[0]);
        if (over_read && !hold_rs) begin
            rx_rs = 1'b0;
            gap = 5;
        end else if (gap > 0) gap--;
    endtask

    task automatic send(input logic [7:0] b, input bit pop_at_cap);
        while (gap > 0) tick();
        rx_data = b;
        rx_rs = 1'b1;
        rs_t = cyc;
        tick();
        tick();
        bus.rd_en = pop_at_cap;
        tick();
        bus.rd_en = 1'b0;
        chk("cap_over_read", over_read, 1);
        rx_rs = 1'b0;
        rs_t = -1;
        gap = 5;
    endtask

    task automatic pop_n(input int n);
        bus.rd_en = 1'b1;
        repeat (n) tick();
        bus.rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        rx_rs = 1'b0;
        rx_data = 8'h00;
        bus.rd_en = 1'b0;
        bus.clr_overrun = 1'b0;
        hold_rs = 1'b0;
        rs_t = -1;
        ovr = 1'b0;
        #1;
        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_over_read", over_read, 0);
        chk("rst_overrun", bus.overrun, 0);
        chk("rst_irq", bus.irq, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        send(8'hA5, 0);
        chk("single_count", bus.count, 1);
        chk("single_data", bus.rd_data, 8'hA5);
        chk("single_irq", bus.irq, 1);
        tick();
        pop_n(1);
        chk("single_pop_empty", bus.empty, 1);
        chk("single_pop_irq", bus.irq, 0);

        while (gap > 0) tick();
        hold_rs = 1'b1;
        rx_data = 8'h42;
        rx_rs = 1'b1;
        rs_t = cyc;
        n0 = n_or;
        repeat (23) tick();
        chk("long_rs_pulses", n_or - n0, 1);
        chk("long_rs_count", bus.count, 1);
        hold_rs = 1'b0;
        rx_rs = 1'b0;
        gap = 5;
        pop_n(1);

        for (int i = 0; i < DEPTH; i++) send(8'(i), 0);
        send(8'hFF, 0);
        chk("fill_full", bus.full, 1);
        chk("fill_count", bus.count, 16);
        chk("fill_overrun", bus.overrun, 1);
        chk("fill_irq", bus.irq, 1);
        for (int i = 0; i < DEPTH; i++) begin
            chk("pop_order", bus.rd_data, i);
            pop_n(1);
        end
        chk("drained_empty", bus.empty, 1);

        bus.clr_overrun = 1'b1;
        tick();
        bus.clr_overrun = 1'b0;
        chk("clr_overrun", bus.overrun, 0);
        for (int i = 0; i < DEPTH; i++) send(8'($urandom), 0);
        send(8'h55, 1);
        chk("pp_full_count", bus.count, 16);
        chk("pp_full_overrun", bus.overrun, 0);
        pop_n(15);
        chk("pp_full_last", bus.rd_data, 8'h55);
        pop_n(1);

        pop_n(3);
        chk("empty_pop_count", bus.count, 0);
        send(8'h3C, 0);
        chk("empty_pop_data", bus.rd_data, 8'h3C);
        pop_n(1);

        while (gap > 0) tick();
        hold_rs = 1'b1;
        rx_data = 8'h77;
        rx_rs = 1'b1;
        rs_t = cyc;
        repeat (3) tick();
        chk("rst_mid_or_high", over_read, 1);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_over_read", over_read, 0);
        chk("rst_mid_count", bus.count, 0);
        chk("rst_mid_empty", bus.empty, 1);
        chk("rst_mid_overrun", bus.overrun, 0);
        q.delete();
        ovr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        rs_t = cyc;
        hold_rs = 1'b0;
        n0 = n_or;
        repeat (10) tick();
        chk("rst_recapture", n_or - n0, 1);
        chk("rst_recap_count", bus.count, 1);
        chk("rst_recap_data", bus.rd_data, 8'h77);

        for (int i = 0; i < 4000; i++) begin
            bus.rd_en = (i < 2000) ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 2) != 0);
            bus.clr_overrun = $urandom_range(0, 40) == 0;
            if (!rx_rs && gap == 0 && $urandom_range(0, 1) == 0) begin
                rx_data = 8'($urandom);
                rx_rs = 1'b1;
                rs_t = cyc;
            end
            tick();
        end
        bus.rd_en = 1'b0;
        bus.clr_overrun = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer directly downstream of the UART receiving unit. It detects the receiver's byte-available status (rs) and captures the 8-bit received byte. It then acknowledges the receiver with a one-cycle over_read pulse and stores the byte in a first-word-fall-through FIFO. The CPU/bus bridge pops bytes from the FIFO, reads status and takes an interrupt request from this block.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth; DEPTH = 2**DEPTH_LOG2 = 16 entries.
IRQ_LEVEL, 1, irq asserts when count >= IRQ_LEVEL; legal range 1..DEPTH.

Ports:
clk  in  1  system clock, same clock as the receiving unit.
rst  in  1  asynchronous, active-low reset.
rx_data  in  8  receiver data register (d_out of the receiving unit).
rx_rs  in  1  receiver status (rs); level, set by the receiver, cleared asynchronously by over_read.
over_read  out  1  one-cycle acknowledge pulse to the receiver; clears rx_rs.
rd_en  in  1  pop request from the bus side.
rd_data  out  8  head-of-FIFO byte; valid whenever empty=0.
empty  out  1  FIFO holds 0 entries.
full  out  1  FIFO holds DEPTH entries.
count  out  DEPTH_LOG2+1  number of stored entries, 0..DEPTH.
overrun  out  1  sticky flag: a byte was dropped because the FIFO was full.
clr_overrun  in  1  synchronous clear of overrun.
irq  out  1  interrupt request = (count >= IRQ_LEVEL) | overrun; registered.

Behaviour:
- Reset (rst=0, async): capture FSM = C_IDLE; rs sync flops = 0; wr_ptr = rd_ptr = 0; count = 0; over_read = 0; overrun = 0; irq = 0; empty = 1; full = 0. rd_data is don't-care while empty.
- rx_rs is produced on a derived clock, so pass it through a 2-flop synchronizer (rs_s1 -> rs_s2). rx_data is stable for many bit-times after rs rises and needs no synchronizer.
- Capture FSM (3 states):
  - C_IDLE: if rs_s2=1, then at that edge write rx_data to mem[wr_ptr] (or drop it, see full rule), set over_read<=1 and go to C_ACK.
  - C_ACK: over_read<=0; go to C_WAIT.
  - C_WAIT: stay until rs_s2=0, then go to C_IDLE. This guarantees exactly one capture per rs assertion.
- Latency: rx_rs rises before edge t0. rs_s2=1 after t1. The write, the count update and over_read=1 occur at t2; over_read=0 at t3. The byte is visible on rd_data / empty=0 after t2.
- Push accept rule: accept if count < DEPTH, or if a legal pop occurs in the same cycle.
  - If not accepted: drop the byte, set overrun<=1, leave pointers unchanged. over_read is still pulsed so the receiver is not stalled.
- Pop: rd_en=1 with empty=1 is ignored, with no pointer or count change. With empty=0, rd_ptr advances at the edge and rd_data shows the next entry.
- Simultaneous push and pop: count unchanged, both pointers advance. This is legal at count=DEPTH and at count=0 is not a pop (empty).
- Pointers are DEPTH_LOG2 bits wide and wrap modulo DEPTH. count uses a separate counter; full = (count==DEPTH), empty = (count==0).
- overrun: set by a dropped push. clr_overrun clears it at the edge; if a set and a clear happen in the same cycle, set wins.
- irq: registered from the next-state count and overrun, so it updates on the same edge as count.
- Reset mid-frame or mid-handshake returns the FSM to C_IDLE and forces over_read=0 immediately. Any pending rx_rs is re-captured after reset release, as a normal assertion.
- Memory: plain register array, no reset on contents.

Decomposition:
- Shared UART header adds the capture-state encodings C_IDLE=0, C_ACK=1, C_WAIT=2 and UART_RXFIFO_DEPTH_LOG2 default 4, next to the existing baud/HALF_BIT constants.
- One natural sub-module: sync_fifo (storage, pointers, count, full/empty, simultaneous push/pop). Capture FSM, synchronizer, overrun and irq logic stay in uart_rx_fifo.

Test Plan:
- Single byte: hold rx_rs=1 with rx_data=0xA5 until over_read is seen, then drop rx_rs.
  -> over_read high exactly 1 cycle, 2 edges after rs_s1 samples 1.
  -> count=1, empty=0, rd_data=0xA5, irq=1.
  -> A subsequent rd_en pulse gives count=0, empty=1, irq=0.
- Long rs: keep rx_rs=1 for 20 cycles after over_read with no clear.
  -> Only one push (count=1), only one over_read pulse.
- Fill to full: push 16 bytes 0x00..0x0F, then a 17th byte 0xFF.
  -> full=1, count=16, overrun=1, irq=1, over_read still pulses.
  -> Popping 16 times yields 0x00..0x0F in order; 0xFF is absent.
- Push and pop same cycle at full: count=16, push 0x55 while rd_en=1.
  -> count stays 16, overrun stays 0, 0x55 becomes the last entry.
- Pop when empty: rd_en=1 for 3 cycles at count=0.
  -> count=0, pointers unchanged. A later push of 0x3C reads back as 0x3C.
- Async reset mid-handshake: assert rst=0 while the FSM is in C_ACK.
  -> over_read=0, count=0, empty=1, overrun=0 immediately, without waiting for a clk edge.
  -> After release with rx_rs still 1, exactly one capture follows.
